// File: rtl/inst_cache_ctrl_pkg.sv
// Shared geometry constants and FSM state type for the instruction-cache miss/refill controller.
// 64 lines x 4 words: tag = addr[31:10], index = addr[9:4], word = addr[3:2].
package inst_cache_ctrl_pkg;

  localparam int ICACHE_INDEX     = 6;
  localparam int ITAGLSB          = 10;
  localparam int ITAGMSB          = 31;
  localparam int ICACHE_WORD_BITS = ITAGLSB - ICACHE_INDEX - 2;
  localparam int ICACHE_SIZE      = 1 << ICACHE_INDEX;
  localparam int ITAG_W           = ITAGMSB - ITAGLSB + 1;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    TAG_WR,
    FLUSH
  } icache_state_t;

endpackage

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped I-cache miss/refill controller: 0-cycle hit, line refill word by word, then tag write.
// Fetch is held via stall during refill/flush; memory words are accepted only on mem_ack.
module inst_cache_ctrl
  import inst_cache_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 fetch_valid,
  input  logic [ADDR_W-1:0]                    fetch_addr,
  input  logic                                 flush,
  output logic                                 stall,
  output logic                                 hit,
  output logic                                 tag_we,
  output logic [ICACHE_INDEX-1:0]              tag_index,
  output logic                                 tag_valid_in,
  output logic [ITAG_W-1:0]                    tag_in,
  input  logic                                 tag_valid_out,
  input  logic [ITAG_W-1:0]                    tag_out,
  output logic                                 dram_we,
  output logic [ICACHE_INDEX+ICACHE_WORD_BITS-1:0] dram_addr,
  output logic [DATA_W-1:0]                    dram_wdata,
  output logic                                 mem_req,
  output logic [ADDR_W-1:0]                    mem_addr,
  input  logic                                 mem_ack,
  input  logic [DATA_W-1:0]                    mem_rdata
);

  localparam int WORD_BITS  = ICACHE_WORD_BITS;
  localparam int LINE_WORDS = 1 << WORD_BITS;
  localparam int IDX_W      = ICACHE_INDEX;

  icache_state_t        state, state_nxt;
  logic [WORD_BITS-1:0] word_cnt, word_cnt_nxt;
  logic [IDX_W-1:0]     flush_cnt, flush_cnt_nxt;
  logic                 flush_pend, flush_pend_nxt;
  logic [ITAG_W-1:0]    lat_tag;
  logic [IDX_W-1:0]     lat_index;
  logic                 lat_en;

  logic [ITAG_W-1:0]    fetch_tag;
  logic [IDX_W-1:0]     fetch_index;
  logic                 lookup_hit;
  logic                 last_word;
  logic                 last_index;
  logic                 unused_addr_bits;

  assign fetch_tag        = fetch_addr[ITAGMSB:ITAGLSB];
  assign fetch_index      = fetch_addr[ITAGLSB-1:ITAGLSB-IDX_W];
  assign unused_addr_bits = ^fetch_addr[ITAGLSB-IDX_W-1:0];
  assign lookup_hit       = fetch_valid & tag_valid_out & (tag_out == fetch_tag);
  assign last_word        = (word_cnt == WORD_BITS'(LINE_WORDS - 1));
  assign last_index       = (flush_cnt == IDX_W'(ICACHE_SIZE - 1));

  always_comb begin
    state_nxt      = state;
    word_cnt_nxt   = word_cnt;
    flush_cnt_nxt  = flush_cnt;
    flush_pend_nxt = flush_pend;
    lat_en         = 1'b0;
    stall          = 1'b0;
    hit            = 1'b0;
    tag_we         = 1'b0;
    tag_index      = fetch_index;
    tag_valid_in   = 1'b0;
    tag_in         = '0;
    dram_we        = 1'b0;
    dram_addr      = {lat_index, word_cnt};
    dram_wdata     = mem_rdata;
    mem_req        = 1'b0;
    mem_addr       = ADDR_W'({lat_tag, lat_index, word_cnt, 2'b00});

    case (state)
      IDLE: begin
        hit = lookup_hit;
        if (flush) begin
          stall         = 1'b1;
          flush_cnt_nxt = '0;
          state_nxt     = FLUSH;
        end else if (fetch_valid && !lookup_hit) begin
          stall        = 1'b1;
          lat_en       = 1'b1;
          word_cnt_nxt = '0;
          state_nxt    = REFILL;
        end
      end

      REFILL: begin
        // A flush arriving mid-line is deferred; the memory transaction always completes.
        stall   = 1'b1;
        mem_req = 1'b1;
        if (flush) flush_pend_nxt = 1'b1;
        if (mem_ack) begin
          dram_we      = 1'b1;
          word_cnt_nxt = word_cnt + 1'b1;
          if (last_word) state_nxt = TAG_WR;
        end
      end

      TAG_WR: begin
        stall        = 1'b1;
        tag_we       = 1'b1;
        tag_valid_in = 1'b1;
        tag_in       = lat_tag;
        tag_index    = lat_index;
        if (flush_pend || flush) begin
          flush_pend_nxt = 1'b1;
          flush_cnt_nxt  = '0;
          state_nxt      = FLUSH;
        end else begin
          state_nxt = IDLE;
        end
      end

      FLUSH: begin
        stall         = 1'b1;
        tag_we        = 1'b1;
        tag_index     = flush_cnt;
        flush_cnt_nxt = flush_cnt + 1'b1;
        if (last_index) begin
          flush_pend_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Strobes are held quiet while reset is asserted so RAMs and memory see nothing.
    if (reset) begin
      stall   = 1'b0;
      hit     = 1'b0;
      tag_we  = 1'b0;
      dram_we = 1'b0;
      mem_req = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      word_cnt   <= '0;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      word_cnt   <= word_cnt_nxt;
      flush_cnt  <= flush_cnt_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (lat_en && !reset) begin
      lat_tag   <= fetch_tag;
      lat_index <= fetch_index;
    end
  end

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Directed bench for inst_cache_ctrl with behavioural tag/data RAMs and an instruction memory responder.
module tb_inst_cache_ctrl;
  import inst_cache_ctrl_pkg::*;

  localparam int IW = ICACHE_INDEX;
  localparam int TW = ITAG_W;
  localparam int DW = ICACHE_INDEX + ICACHE_WORD_BITS;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic          clock, reset, fetch_valid, flush;
  logic [31:0]   fetch_addr;
  logic          stall, hit, tag_we, tag_valid_in, tag_valid_out, dram_we, mem_req, mem_ack;
  logic [IW-1:0] tag_index;
  logic [TW-1:0] tag_in, tag_out;
  logic [DW-1:0] dram_addr;
  logic [31:0]   dram_wdata, mem_addr, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_delay = 0;
  bit stray_ack = 1'b0;

  logic          tv   [ICACHE_SIZE];
  logic [TW-1:0] tt   [ICACHE_SIZE];
  logic [31:0]   dram [1<<DW];

  logic [31:0]   req_log[$];
  logic [31:0]   ack_log[$];
  logic [DW-1:0] dlog_a[$];
  logic [31:0]   dlog_d[$];
  logic [IW-1:0] tw_idx[$];
  logic          tw_val[$];
  logic [TW-1:0] tw_tag[$];

  inst_cache_ctrl dut (
    .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .flush(flush),
    .stall(stall), .hit(hit), .tag_we(tag_we), .tag_index(tag_index), .tag_valid_in(tag_valid_in),
    .tag_in(tag_in), .tag_valid_out(tag_valid_out), .tag_out(tag_out), .dram_we(dram_we),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  assign tag_valid_out = tv[tag_index];
  assign tag_out       = tt[tag_index];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Tag and data RAMs: combinational read, write on the rising edge.
  initial begin
    for (int i = 0; i < ICACHE_SIZE; i++) begin
      tv[i] = 1'b0;
      tt[i] = '0;
    end
    forever begin
      @(posedge clock);
      if (tag_we) begin
        tv[tag_index] = tag_valid_in;
        tt[tag_index] = tag_in;
      end
      if (dram_we) dram[dram_addr] = dram_wdata;
    end
  end

  // Memory: acks after ack_delay idle request cycles; stray_ack forces an unsolicited ack.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      #1;
      mem_ack = 1'b0;
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        wait_cnt  = 0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr ^ KEY;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (mem_req) req_log.push_back(mem_addr);
      if (mem_req && mem_ack) ack_log.push_back(mem_addr);
      if (dram_we) begin
        dlog_a.push_back(dram_addr);
        dlog_d.push_back(dram_wdata);
      end
      if (tag_we) begin
        tw_idx.push_back(tag_index);
        tw_val.push_back(tag_valid_in);
        tw_tag.push_back(tag_in);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    req_log.delete(); ack_log.delete(); dlog_a.delete(); dlog_d.delete();
    tw_idx.delete(); tw_val.delete(); tw_tag.delete();
  endtask

  // Presents one fetch and holds it until the controller reports a hit (bounded).
  task automatic do_fetch(input logic [31:0] a, output int stalls, output bit got_hit);
    @(negedge clock);
    clear_logs();
    fetch_valid = 1'b1;
    fetch_addr  = a;
    stalls      = 0;
    got_hit     = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #2;
      if (hit && !stall) begin
        got_hit = 1'b1;
        break;
      end
      if (stall) stalls++;
      @(negedge clock);
    end
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b1; fetch_valid = 1'b1; fetch_addr = 32'h40;
    repeat (3) @(negedge clock);
    #2;
    n_tests++; if (stall !== 1'b0)   begin n_fail++; $display("FAIL rst_stall: got %b expected 0", stall); end
    n_tests++; if (hit !== 1'b0)     begin n_fail++; $display("FAIL rst_hit: got %b expected 0", hit); end
    n_tests++; if (tag_we !== 1'b0)  begin n_fail++; $display("FAIL rst_tag_we: got %b expected 0", tag_we); end
    n_tests++; if (dram_we !== 1'b0) begin n_fail++; $display("FAIL rst_dram_we: got %b expected 0", dram_we); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    reset = 1'b0; flush = 1'b0; fetch_valid = 1'b0;
    @(negedge clock);
    #2;
    n_tests++; if (stall !== 1'b0)  begin n_fail++; $display("FAIL idle_stall: got %b expected 0", stall); end
    n_tests++; if (tag_we !== 1'b0) begin n_fail++; $display("FAIL idle_tag_we: got %b expected 0", tag_we); end
    fetch_valid = 1'b1; fetch_addr = 32'h40;
    #1;
    n_tests++; if (stall !== 1'b1)   begin n_fail++; $display("FAIL miss_comb_stall: got %b expected 1", stall); end
    n_tests++; if (hit !== 1'b0)     begin n_fail++; $display("FAIL miss_comb_hit: got %b expected 0", hit); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL miss_idle_req: got %b expected 0", mem_req); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_cold_miss();
    int s; bit h;
    do_fetch(32'h40, s, h);
    n_tests++; if (h !== 1'b1) begin n_fail++; $display("FAIL cold_hit: got %b expected 1", h); end
    n_tests++; if (s != 6)     begin n_fail++; $display("FAIL cold_stalls: got %0d expected 6", s); end
    n_tests++; if (req_log.size() != 4) begin n_fail++; $display("FAIL cold_req_cycles: got %0d expected 4", req_log.size()); end
    n_tests++; if (ack_log.size() != 4) begin n_fail++; $display("FAIL cold_acks: got %0d expected 4", ack_log.size()); end
    for (int i = 0; i < ack_log.size() && i < 4; i++) begin
      n_tests++;
      if (ack_log[i] !== 32'h40 + 32'(4*i)) begin n_fail++; $display("FAIL cold_mem_addr%0d: got %h expected %h", i, ack_log[i], 32'h40 + 32'(4*i)); end
    end
    n_tests++; if (dlog_a.size() != 4) begin n_fail++; $display("FAIL cold_dram_writes: got %0d expected 4", dlog_a.size()); end
    for (int i = 0; i < dlog_a.size() && i < 4; i++) begin
      n_tests++;
      if (dlog_a[i] !== DW'(8'h10 + 8'(i)) || dlog_d[i] !== ((32'h40 + 32'(4*i)) ^ KEY)) begin
        n_fail++; $display("FAIL cold_dram%0d: got %h/%h expected %h/%h", i, dlog_a[i], dlog_d[i], 8'h10 + 8'(i), (32'h40 + 32'(4*i)) ^ KEY);
      end
    end
    n_tests++;
    if (tw_idx.size() != 1 || tw_idx[0] !== IW'(4) || tw_val[0] !== 1'b1 || tw_tag[0] !== TW'(0)) begin
      n_fail++; $display("FAIL cold_tag_write: got %0d writes (first idx %0d val %b tag %h) expected 1 write idx 4 val 1 tag 0",
                         tw_idx.size(), tw_idx.size() > 0 ? tw_idx[0] : '0, tw_val.size() > 0 ? tw_val[0] : 1'b0, tw_tag.size() > 0 ? tw_tag[0] : '0);
    end
  endtask

  task automatic test_back_to_back();
    int s; bit h;
    do_fetch(32'h44, s, h);
    n_tests++; if (h !== 1'b1 || s != 0) begin n_fail++; $display("FAIL same_line_hit: got hit %b stalls %0d expected 1/0", h, s); end
    do_fetch(32'h4C, s, h);
    n_tests++; if (h !== 1'b1 || s != 0) begin n_fail++; $display("FAIL last_word_hit: got hit %b stalls %0d expected 1/0", h, s); end
  endtask

  task automatic test_conflict();
    int s; bit h;
    do_fetch(32'h440, s, h);
    n_tests++; if (h !== 1'b1 || s != 6) begin n_fail++; $display("FAIL conflict_miss: got hit %b stalls %0d expected 1/6", h, s); end
    n_tests++; if (ack_log.size() != 4 || ack_log[0] !== 32'h440 || ack_log[3] !== 32'h44C) begin
      n_fail++; $display("FAIL conflict_addrs: got %0d acks expected 4 from 440 to 44c", ack_log.size());
    end
    n_tests++; if (tw_idx.size() != 1 || tw_idx[0] !== IW'(4) || tw_tag[0] !== TW'(1)) begin
      n_fail++; $display("FAIL conflict_tag: got %0d writes expected 1 write idx 4 tag 1", tw_idx.size());
    end
    n_tests++; if (dram[8'h10] !== (32'h440 ^ KEY)) begin n_fail++; $display("FAIL conflict_data: got %h expected %h", dram[8'h10], 32'h440 ^ KEY); end
    do_fetch(32'h40, s, h);
    n_tests++; if (h !== 1'b1 || s != 6) begin n_fail++; $display("FAIL evicted_miss: got hit %b stalls %0d expected 1/6", h, s); end
  endtask

  task automatic test_slow_mem();
    int s; bit h;
    ack_delay = 2;
    do_fetch(32'h80, s, h);
    ack_delay = 0;
    n_tests++; if (h !== 1'b1 || s != 14) begin n_fail++; $display("FAIL slow_stalls: got hit %b stalls %0d expected 1/14", h, s); end
    n_tests++; if (req_log.size() != 12) begin n_fail++; $display("FAIL slow_req_cycles: got %0d expected 12", req_log.size()); end
    for (int i = 0; i < req_log.size() && i < 12; i++) begin
      n_tests++;
      if (req_log[i] !== 32'h80 + 32'(4*(i/3))) begin n_fail++; $display("FAIL slow_hold%0d: got %h expected %h", i, req_log[i], 32'h80 + 32'(4*(i/3))); end
    end
    n_tests++; if (dlog_a.size() != 4 || dlog_a[0] !== DW'(8'h20) || dlog_a[3] !== DW'(8'h23)) begin
      n_fail++; $display("FAIL slow_dram_writes: got %0d expected 4 at 20..23", dlog_a.size());
    end
  endtask

  task automatic test_flush();
    int cyc; int s; bit h; bit bad;
    @(negedge clock);
    clear_logs();
    flush = 1'b1;
    #2;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall: got %b expected 1", stall); end
    @(negedge clock);
    flush = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (!stall) break;
      cyc++;
      @(negedge clock);
    end
    n_tests++; if (cyc != 64) begin n_fail++; $display("FAIL flush_cycles: got %0d expected 64", cyc); end
    n_tests++; if (tw_idx.size() != 64) begin n_fail++; $display("FAIL flush_writes: got %0d expected 64", tw_idx.size()); end
    bad = 1'b0;
    for (int i = 0; i < tw_idx.size() && i < 64; i++)
      if (tw_idx[i] !== IW'(i) || tw_val[i] !== 1'b0 || tw_tag[i] !== TW'(0)) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL flush_sequence: got bad entries expected idx 0..63 val 0 tag 0"); end
    do_fetch(32'h40, s, h);
    n_tests++; if (h !== 1'b1 || s != 6) begin n_fail++; $display("FAIL post_flush_miss: got hit %b stalls %0d expected 1/6", h, s); end
  endtask

  task automatic test_flush_in_refill();
    int s; bit h; bit bad;
    @(negedge clock);
    clear_logs();
    s = 0;
    for (int i = 0; i < 300; i++) begin
      fetch_valid = (i == 0);
      fetch_addr  = 32'hC0;
      flush       = (i == 2);
      #2;
      if (!stall) break;
      s++;
      @(negedge clock);
    end
    flush = 1'b0;
    n_tests++; if (s != 70) begin n_fail++; $display("FAIL fir_stalls: got %0d expected 70", s); end
    n_tests++; if (dlog_a.size() != 4) begin n_fail++; $display("FAIL fir_dram_writes: got %0d expected 4", dlog_a.size()); end
    n_tests++; if (tw_idx.size() != 65) begin n_fail++; $display("FAIL fir_tag_writes: got %0d expected 65", tw_idx.size()); end
    n_tests++; if (tw_idx.size() > 0 && (tw_idx[0] !== IW'(12) || tw_val[0] !== 1'b1)) begin
      n_fail++; $display("FAIL fir_tag_wr: got idx %0d val %b expected 12/1", tw_idx[0], tw_val[0]);
    end
    bad = 1'b0;
    for (int i = 1; i < tw_idx.size() && i < 65; i++)
      if (tw_idx[i] !== IW'(i-1) || tw_val[i] !== 1'b0) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL fir_flush_seq: got bad entries expected idx 0..63 val 0"); end
    do_fetch(32'h40, s, h);
    n_tests++; if (h !== 1'b1 || s != 6) begin n_fail++; $display("FAIL fir_post_miss: got hit %b stalls %0d expected 1/6", h, s); end
  endtask

  task automatic test_reset_mid_refill();
    int s; bit h;
    @(negedge clock);
    clear_logs();
    fetch_valid = 1'b1;
    fetch_addr  = 32'h100;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #2;
    n_tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rmr_in_reset: got req %b stall %b expected 0/0", mem_req, stall); end
    @(negedge clock);
    reset     = 1'b0;
    stray_ack = 1'b1;
    #2;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rmr_req_after: got %b expected 0", mem_req); end
    n_tests++; if (dram_we !== 1'b0) begin n_fail++; $display("FAIL rmr_stray_we: got %b expected 0", dram_we); end
    n_tests++; if (dlog_a.size() != 2) begin n_fail++; $display("FAIL rmr_partial: got %0d expected 2", dlog_a.size()); end
    stray_ack = 1'b0;
    s = 0; h = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) begin @(negedge clock); #2; end
      if (hit && !stall) begin h = 1'b1; break; end
      if (stall) s++;
    end
    fetch_valid = 1'b0;
    n_tests++; if (h !== 1'b1 || s != 6) begin n_fail++; $display("FAIL rmr_refill: got hit %b stalls %0d expected 1/6", h, s); end
    n_tests++; if (dlog_a.size() != 6 || dlog_a[2] !== DW'(8'h40) || dlog_a[5] !== DW'(8'h43) || dlog_d[5] !== (32'h10C ^ KEY)) begin
      n_fail++; $display("FAIL rmr_words: got %0d writes expected 6 ending 40..43", dlog_a.size());
    end
    n_tests++; if (tw_idx.size() != 1 || tw_idx[0] !== IW'(16)) begin n_fail++; $display("FAIL rmr_tag: got %0d writes expected 1 at idx 16", tw_idx.size()); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_addr = '0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_slow_mem();
    test_flush();
    test_flush_in_refill();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
